branch_unit: RTL
================

# branch_unit

Parametrised branch resolution and prediction unit for the simplerv core, successor to the combinational taken/not-taken decoder. It compares the two register operands itself, resolves RV32/RV64 conditional branches (funct3 000/001/100/101/110/111), and keeps a bimodal branch history table (BHT) of 2-bit saturating counters. The BHT serves next-cycle predictions to fetch and flags mispredictions to the pipeline control. The unit sits between decode/execute, which supply resolve requests, and fetch, which issues predict lookups.

## Interface
- XLEN, default 32: operand width in bits (32 or 64).
- BHT_IDX_W, default 6: BHT index width; depth = 2^BHT_IDX_W entries.
- clk  in  1  core clock, rising edge.
- rst_n  in  1  reset, asynchronous assertion, active-low.
- pred_valid  in  1  fetch lookup request.
- pred_pc  in  XLEN  fetch PC. Index = pred_pc[BHT_IDX_W+1:2].
- pred_out_valid  out  1  registered lookup result valid.
- pred_out_taken  out  1  registered prediction: counter MSB.
- res_valid  in  1  resolve request from execute.
- res_pc  in  XLEN  PC of the branch being resolved.
- res_funct3  in  3  branch funct3.
- res_rs1, res_rs2  in  XLEN  operands.
- res_pred_taken  in  1  prediction fetch used for this branch.
- out_valid  out  1  registered resolve result valid.
- out_taken  out  1  resolved direction.
- out_mispredict  out  1  out_taken != res_pred_taken; only meaningful when out_valid.
- out_illegal  out  1  funct3 was 010 or 011.

## Operation
- Compare, signed and unsigned, over full XLEN: eq = rs1==rs2; less = $signed(rs1)<$signed(rs2); less_u = rs1<rs2; ge = !less; ge_u = !less_u.
- Direction: 000 eq; 001 !eq; 100 less; 101 ge; 110 less_u; 111 ge_u.
- 010 and 011 resolve to taken=0 and illegal=1; mispredict is computed normally; the BHT is not updated.
- BHT counters: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T. On a legal resolve, increment the counter if taken, decrement it if not taken, and saturate at 11/00.
- Update index = res_pc[BHT_IDX_W+1:2].
- Same-cycle lookup and update to the same index: the prediction returns the post-update counter MSB (write bypass). Different indices are independent.
- No backpressure. Every valid request is accepted every cycle.

## Timing
- Lookup latency 1: pred_valid at edge N gives pred_out_* valid after edge N+1. pred_out_valid = registered pred_valid.
- Resolve latency 1: out_* registered at edge N+1 for a request sampled at edge N. The BHT write commits on the same edge.
- Back-to-back resolves to the same index each see the prior update: two consecutive taken resolves from 01 give 10, then 11.
- While out_valid is 0, out_taken, out_mispredict and out_illegal are held at 0.
- Reset (async, any time, including mid-request): all outputs 0, all BHT counters 01, in-flight requests dropped. Release is synchronised externally. The first edge after release samples inputs normally.

## Configuration
- BRANCH_PERF_EN defined: adds outputs perf_branches and perf_mispredicts, each 32 bits.
  - These count legal resolves and legal mispredicts.
  - They wrap modulo 2^32 and reset to 0.
  - Increments are visible one cycle after out_valid.
- BRANCH_PERF_EN undefined: the ports and counters are absent and behaviour is otherwise identical.

## Structure
- branch_pkg holds:
  - funct3 localparams: BEQ, BNE, BLT, BGE, BLTU, BGEU.
  - the bht_ctr_t 2-bit typedef, with constants CTR_SNT, CTR_WNT, CTR_WT, CTR_ST.
  - the counter-reset constant CTR_WNT.
- One sub-module, branch_cmp: combinational, parametrised by XLEN, takes funct3, rs1, rs2 and produces taken and illegal.
- The BHT array and update/bypass logic live in branch_unit.

## Test plan
- Reset then lookup: pred_pc=0x40 after reset gives pred_out_taken=0 for every index.
- Compare corners with XLEN=32:
  - BLT, rs1=0xFFFFFFFF, rs2=1: taken=1.
  - BLTU, same operands: taken=0.
  - BGE, equal operands: taken=1.
  - BNE, equal operands: taken=0.
- Training: three taken BEQ resolves at pc 0x100 move the counter 01 to 10 to 11 to 11. One not-taken moves it to 10. A lookup at 0x100 then gives taken=1.
- Mispredict: BNE with rs1!=rs2 and res_pred_taken=0 gives out_taken=1, out_mispredict=1 one cycle later.
- Bypass: a lookup of 0x200 in the same cycle as a taken resolve of 0x200 with counter 01 gives pred_out_taken=1.
- Illegal and reset: funct3=010 gives out_illegal=1 and the counter is unchanged. Asserting rst_n low mid-stream clears outputs immediately and the BHT reads 01. With BRANCH_PERF_EN defined, the counters read 0 after reset.

Source files
------------

// File: rtl/branch_pkg.sv
// rtl/branch_pkg.sv - shared constants, counter type and saturating-update helper for the branch unit
// Purpose: funct3 encodings of the conditional branches, the 2-bit BHT counter
//          type with its four states, the counter reset value, and the
//          saturating increment/decrement used on every legal resolve.
// Ports:   none (package).
package branch_pkg;

   localparam logic [2:0] BEQ  = 3'b000;
   localparam logic [2:0] BNE  = 3'b001;
   localparam logic [2:0] BLT  = 3'b100;
   localparam logic [2:0] BGE  = 3'b101;
   localparam logic [2:0] BLTU = 3'b110;
   localparam logic [2:0] BGEU = 3'b111;

   typedef logic [1:0] bht_ctr_t;

   localparam bht_ctr_t CTR_SNT = 2'b00;
   localparam bht_ctr_t CTR_WNT = 2'b01;
   localparam bht_ctr_t CTR_WT  = 2'b10;
   localparam bht_ctr_t CTR_ST  = 2'b11;

   // Every counter leaves reset weakly not-taken.
   localparam bht_ctr_t CTR_RESET = CTR_WNT;

   function automatic bht_ctr_t ctr_next(input bht_ctr_t cur, input logic taken);
      if (taken)
         return (cur == CTR_ST) ? CTR_ST : bht_ctr_t'(cur + 2'd1);
      else
         return (cur == CTR_SNT) ? CTR_SNT : bht_ctr_t'(cur - 2'd1);
   endfunction

endpackage

// File: rtl/branch_unit_if.sv
// rtl/branch_unit_if.sv - lookup and resolve signal bundle between fetch/execute and the branch unit
// Purpose: groups the fetch lookup channel and the execute resolve channel.
// Ports:   master = fetch/execute side (drives requests, receives results)
//          slave  = branch unit (receives requests, drives results)
//          pred_valid/pred_pc -> pred_out_valid/pred_out_taken
//          res_valid/res_pc/res_funct3/res_rs1/res_rs2/res_pred_taken
//             -> out_valid/out_taken/out_mispredict/out_illegal
interface branch_unit_if #(
   parameter int XLEN = 32
);
   logic            pred_valid;
   logic [XLEN-1:0] pred_pc;
   logic            pred_out_valid;
   logic            pred_out_taken;

   logic            res_valid;
   logic [XLEN-1:0] res_pc;
   logic [2:0]      res_funct3;
   logic [XLEN-1:0] res_rs1;
   logic [XLEN-1:0] res_rs2;
   logic            res_pred_taken;
   logic            out_valid;
   logic            out_taken;
   logic            out_mispredict;
   logic            out_illegal;

   modport master (
      output pred_valid, pred_pc,
      output res_valid, res_pc, res_funct3, res_rs1, res_rs2, res_pred_taken,
      input  pred_out_valid, pred_out_taken,
      input  out_valid, out_taken, out_mispredict, out_illegal
   );

   modport slave (
      input  pred_valid, pred_pc,
      input  res_valid, res_pc, res_funct3, res_rs1, res_rs2, res_pred_taken,
      output pred_out_valid, pred_out_taken,
      output out_valid, out_taken, out_mispredict, out_illegal
   );
endinterface

// File: rtl/branch_cmp.sv
// rtl/branch_cmp.sv - combinational operand compare and branch direction decode
// Purpose: resolves a conditional branch direction from funct3 and the two
//          register operands over the full XLEN.
// Ports:   funct3 (in, 3), rs1/rs2 (in, XLEN),
//          taken (out, 1), illegal (out, 1: funct3 010/011).
module branch_cmp
   import branch_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [2:0]      funct3,
   input  logic [XLEN-1:0] rs1,
   input  logic [XLEN-1:0] rs2,
   output logic            taken,
   output logic            illegal
);

   logic eq;
   logic less;
   logic less_u;

   assign eq     = (rs1 == rs2);
   assign less   = ($signed(rs1) < $signed(rs2));
   assign less_u = (rs1 < rs2);

   always_comb begin
      taken   = 1'b0;
      illegal = 1'b0;
      case (funct3)
         BEQ:     taken = eq;
         BNE:     taken = !eq;
         BLT:     taken = less;
         BGE:     taken = !less;
         BLTU:    taken = less_u;
         BGEU:    taken = !less_u;
         default: illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/branch_unit.sv
// rtl/branch_unit.sv - branch resolution plus bimodal 2-bit BHT prediction
// Purpose: resolves branches from execute, trains a table of 2-bit saturating
//          counters on legal resolves, and answers fetch lookups one cycle
//          later with the counter MSB (bypassing a same-cycle update).
// Ports:   clk, rst_n (async assert, active-low)
//          bus (branch_unit_if.slave): lookup and resolve channels
//          perf_branches, perf_mispredicts (out, 32) when BRANCH_PERF_EN is defined
// Config:  BRANCH_PERF_EN adds wrapping counters of legal resolves/mispredicts.
module branch_unit
   import branch_pkg::*;
#(
   parameter int XLEN      = 32,
   parameter int BHT_IDX_W = 6
) (
   input  logic           clk,
   input  logic           rst_n,
   branch_unit_if.slave   bus
`ifdef BRANCH_PERF_EN
   ,
   output logic [31:0]    perf_branches,
   output logic [31:0]    perf_mispredicts
`endif
);

   localparam int DEPTH = 1 << BHT_IDX_W;

   bht_ctr_t             bht [DEPTH];
   logic [BHT_IDX_W-1:0] pred_idx;
   logic [BHT_IDX_W-1:0] upd_idx;
   logic                 cmp_taken;
   logic                 cmp_illegal;
   logic                 upd_en;
   bht_ctr_t             upd_ctr;
   logic                 pred_bit;
   logic                 unused_pc;

   branch_cmp #(.XLEN(XLEN)) u_cmp (
      .funct3  (bus.res_funct3),
      .rs1     (bus.res_rs1),
      .rs2     (bus.res_rs2),
      .taken   (cmp_taken),
      .illegal (cmp_illegal)
   );

   // Instructions are word aligned, so the two low PC bits never index.
   assign pred_idx  = bus.pred_pc[BHT_IDX_W+1:2];
   assign upd_idx   = bus.res_pc[BHT_IDX_W+1:2];
   assign unused_pc = ^{bus.pred_pc[XLEN-1:BHT_IDX_W+2], bus.pred_pc[1:0],
                        bus.res_pc[XLEN-1:BHT_IDX_W+2], bus.res_pc[1:0]};

   assign upd_en  = bus.res_valid && !cmp_illegal;
   assign upd_ctr = ctr_next(bht[upd_idx], cmp_taken);

   // A lookup colliding with this cycle's update sees the value being written.
   assign pred_bit = (upd_en && (upd_idx == pred_idx)) ? upd_ctr[1] : bht[pred_idx][1];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) bht[i] <= CTR_RESET;
      end else if (upd_en) begin
         bht[upd_idx] <= upd_ctr;
      end
   end

   // Result qualifiers are folded in so the flags read 0 while invalid.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus.pred_out_valid <= 1'b0;
         bus.pred_out_taken <= 1'b0;
         bus.out_valid      <= 1'b0;
         bus.out_taken      <= 1'b0;
         bus.out_mispredict <= 1'b0;
         bus.out_illegal    <= 1'b0;
      end else begin
         bus.pred_out_valid <= bus.pred_valid;
         bus.pred_out_taken <= bus.pred_valid && pred_bit;
         bus.out_valid      <= bus.res_valid;
         bus.out_taken      <= bus.res_valid && cmp_taken;
         bus.out_mispredict <= bus.res_valid && (cmp_taken != bus.res_pred_taken);
         bus.out_illegal    <= bus.res_valid && cmp_illegal;
      end
   end

`ifdef BRANCH_PERF_EN
   // Counted from the registered result, hence one cycle behind out_valid.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perf_branches    <= 32'd0;
         perf_mispredicts <= 32'd0;
      end else if (bus.out_valid && !bus.out_illegal) begin
         perf_branches <= perf_branches + 32'd1;
         if (bus.out_mispredict) perf_mispredicts <= perf_mispredicts + 32'd1;
      end
   end
`endif

endmodule
